// File: rtl/dual_issue_scheduler.sv
// rtl/dual_issue_scheduler.sv - dual-issue RV32I scheduler with load-use scoreboard and branch hold
//
// Purpose: decides each cycle whether the two oldest window instructions issue
// (0, 1 or 2 of them), drives the window flow-control flags, and registers the
// issue slots towards the execute pipes.
// Optional feature macro: SCHED_PERF_EN (adds perf_issued / perf_stall counters).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   nothing_filled           window empty
//   instruction0/1           oldest / next instruction in the window
//   exec_ready               execute pipes can accept this cycle
//   freeze1, freeze2         window must not slide / must not advance PC (comb)
//   dependency_on_ins2       only ins0 issues, window slides by one (comb)
//   issue0_valid/_instr      pipe-0 slot (registered)
//   issue1_valid/_instr      pipe-1 slot (registered)
//   perf_issued, perf_stall  issued-instruction and frozen-cycle counters (SCHED_PERF_EN)

module dual_issue_scheduler #(
    parameter int LOAD_LAT   = 2,
    parameter int BRANCH_LAT = 2
`ifdef SCHED_PERF_EN
    ,
    parameter int PERF_W     = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nothing_filled,
    input  logic [31:0] instruction0,
    input  logic [31:0] instruction1,
    input  logic        exec_ready,
    output logic        freeze1,
    output logic        freeze2,
    output logic        dependency_on_ins2,
    output logic        issue0_valid,
    output logic [31:0] issue0_instr,
    output logic        issue1_valid,
    output logic [31:0] issue1_instr
`ifdef SCHED_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_issued,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [0:0] {RUN, BR_WAIT} state_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
        return !(opc == OPC_BRANCH || opc == OPC_STORE) && (rd != 5'd0);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] opc);
        return (opc == OPC_BRANCH || opc == OPC_JAL || opc == OPC_JALR);
    endfunction

    function automatic logic is_mem(input logic [6:0] opc);
        return (opc == OPC_LOAD || opc == OPC_STORE);
    endfunction

    state_t     state, state_nx;
    logic [2:0] bcnt, bcnt_nx;
    logic [2:0] cnt [0:31];   // cnt[0] stays 0 so x0 reads never stall

    logic [6:0] opc0, opc1;
    logic [4:0] rd0, rs1_0, rs2_0, rd1, rs1_1, rs2_1;
    logic       w0, w1, haz0, haz1, raw01, blk0, can_dual;
    logic       do0, do1, ld0, ld1;

    assign opc0  = instruction0[6:0];
    assign rd0   = instruction0[11:7];
    assign rs1_0 = instruction0[19:15];
    assign rs2_0 = instruction0[24:20];
    assign opc1  = instruction1[6:0];
    assign rd1   = instruction1[11:7];
    assign rs1_1 = instruction1[19:15];
    assign rs2_1 = instruction1[24:20];

    assign w0 = writes_rd(opc0, rd0);
    assign w1 = writes_rd(opc1, rd1);

    // Pending load results; ALU results are forwarded and never create entries.
    assign haz0 = (uses_rs1(opc0) && cnt[rs1_0] != 3'd0) || (uses_rs2(opc0) && cnt[rs2_0] != 3'd0);
    assign haz1 = (uses_rs1(opc1) && cnt[rs1_1] != 3'd0) || (uses_rs2(opc1) && cnt[rs2_1] != 3'd0);

    // ins1 reading ins0's destination in the same cycle cannot be forwarded.
    assign raw01 = w0 && ((uses_rs1(opc1) && rs1_1 == rd0) || (uses_rs2(opc1) && rs2_1 == rd0));

    assign blk0 = nothing_filled || (instruction0 == 32'd0) || haz0;

    assign can_dual = (instruction1 != 32'd0) && !raw01 && !haz1
                   && !(w0 && w1 && rd0 == rd1)
                   && !(is_mem(opc0) && is_mem(opc1))
                   && !is_ctrl(opc0) && !is_ctrl(opc1);

    always_comb begin
        state_nx           = state;
        bcnt_nx            = bcnt;
        freeze1            = 1'b0;
        freeze2            = 1'b0;
        dependency_on_ins2 = 1'b0;
        do0                = 1'b0;
        do1                = 1'b0;
        case (state)
            RUN: begin
                if (nothing_filled) begin
                    // leave the window free to fill
                end else if (!exec_ready || blk0) begin
                    freeze1 = 1'b1;
                    freeze2 = 1'b1;
                end else begin
                    do0 = 1'b1;
                    if (can_dual) begin
                        do1 = 1'b1;
                    end else begin
                        dependency_on_ins2 = 1'b1;
                    end
                    // CTRL never dual-issues, so only ins0 can be the redirect.
                    if (is_ctrl(opc0)) begin
                        state_nx = BR_WAIT;
                        bcnt_nx  = 3'(BRANCH_LAT);
                    end
                end
            end
            BR_WAIT: begin
                freeze1 = 1'b1;
                freeze2 = 1'b1;
                bcnt_nx = bcnt - 3'd1;
                if (bcnt <= 3'd1) begin
                    state_nx = RUN;
                end
            end
            default: state_nx = RUN;
        endcase
    end

    // At most one load issues per cycle because two MEM ops never pair.
    assign ld0 = do0 && (opc0 == OPC_LOAD) && (rd0 != 5'd0);
    assign ld1 = do1 && (opc1 == OPC_LOAD) && (rd1 != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            bcnt  <= 3'd0;
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= 3'd0;
            end
        end else begin
            state <= state_nx;
            bcnt  <= bcnt_nx;
            for (int i = 1; i < 32; i++) begin
                if ((ld0 && rd0 == 5'(i)) || (ld1 && rd1 == 5'(i))) begin
                    cnt[i] <= 3'(LOAD_LAT);
                end else if (cnt[i] != 3'd0) begin
                    cnt[i] <= cnt[i] - 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue0_valid <= 1'b0;
            issue0_instr <= 32'd0;
            issue1_valid <= 1'b0;
            issue1_instr <= 32'd0;
        end else begin
            issue0_valid <= do0;
            issue0_instr <= do0 ? instruction0 : 32'd0;
            issue1_valid <= do1;
            issue1_instr <= do1 ? instruction1 : 32'd0;
        end
    end

`ifdef SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            perf_issued <= perf_issued + PERF_W'(do0) + PERF_W'(do1);
            perf_stall  <= perf_stall + PERF_W'(freeze1);
        end
    end
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// tb/tb_dual_issue_scheduler.sv - self-checking bench for dual_issue_scheduler

module tb_dual_issue_scheduler;

    localparam int LOAD_LAT   = 2;
    localparam int BRANCH_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        nothing_filled;
    logic [31:0] instruction0, instruction1;
    logic        exec_ready;
    logic        freeze1, freeze2, dependency_on_ins2;
    logic        issue0_valid, issue1_valid;
    logic [31:0] issue0_instr, issue1_instr;
`ifdef SCHED_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    always #5 clk = ~clk;

    dual_issue_scheduler #(.LOAD_LAT(LOAD_LAT), .BRANCH_LAT(BRANCH_LAT)) dut (
        .clk                (clk),
        .rst                (rst),
        .nothing_filled     (nothing_filled),
        .instruction0       (instruction0),
        .instruction1       (instruction1),
        .exec_ready         (exec_ready),
        .freeze1            (freeze1),
        .freeze2            (freeze2),
        .dependency_on_ins2 (dependency_on_ins2),
        .issue0_valid       (issue0_valid),
        .issue0_instr       (issue0_instr),
        .issue1_valid       (issue1_valid),
        .issue1_instr       (issue1_instr)
`ifdef SCHED_PERF_EN
        ,
        .perf_issued        (perf_issued),
        .perf_stall         (perf_stall)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: absolute cycle numbers, not countdowns.
    int cyc = 0;
    int ready_at [32];     // first cycle at which a loaded register may be read
    int hold_until = 0;    // first cycle issue is allowed again after a redirect
    int exp_issued = 0;
    int exp_stall  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit reads1(input logic [31:0] x);
        case (x[6:0])
            7'h37, 7'h17, 7'h6f: return 1'b0;
            default:             return 1'b1;
        endcase
    endfunction

    function automatic bit reads2(input logic [31:0] x);
        return x[6:0] == 7'h63 || x[6:0] == 7'h23 || x[6:0] == 7'h33;
    endfunction

    function automatic bit writes(input logic [31:0] x);
        return x[6:0] != 7'h63 && x[6:0] != 7'h23 && x[11:7] != 5'd0;
    endfunction

    function automatic bit is_ctrl(input logic [31:0] x);
        return x[6:0] == 7'h63 || x[6:0] == 7'h6f || x[6:0] == 7'h67;
    endfunction

    function automatic bit is_mem(input logic [31:0] x);
        return x[6:0] == 7'h03 || x[6:0] == 7'h23;
    endfunction

    function automatic bit busy(input logic [31:0] x);
        bit b = 1'b0;
        if (reads1(x) && x[19:15] != 5'd0 && cyc < ready_at[x[19:15]]) b = 1'b1;
        if (reads2(x) && x[24:20] != 5'd0 && cyc < ready_at[x[24:20]]) b = 1'b1;
        return b;
    endfunction

    function automatic bit pairable(input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return 1'b0;
        if (is_ctrl(a) || is_ctrl(b)) return 1'b0;
        if (is_mem(a) && is_mem(b)) return 1'b0;
        if (writes(a) && writes(b) && a[11:7] == b[11:7]) return 1'b0;
        if (writes(a) && reads1(b) && b[19:15] == a[11:7]) return 1'b0;
        if (writes(a) && reads2(b) && b[24:20] == a[11:7]) return 1'b0;
        if (busy(b)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        hold_until = 0;
        exp_issued = 0;
        exp_stall  = 0;
    endtask

    task automatic step(input bit nf, input logic [31:0] i0, input logic [31:0] i1, input bit er);
        bit e_f, e_dep, e_d0, e_d1;
        e_f = 0; e_dep = 0; e_d0 = 0; e_d1 = 0;
        nothing_filled = nf;
        instruction0   = i0;
        instruction1   = i1;
        exec_ready     = er;
        if (cyc < hold_until) e_f = 1;
        else if (nf) e_f = 0;
        else if (!er || i0 == 32'd0 || busy(i0)) e_f = 1;
        else begin
            e_d0 = 1;
            if (pairable(i0, i1)) e_d1 = 1;
            else e_dep = 1;
        end
        @(negedge clk);
        chk("freeze1", 32'(freeze1), 32'(e_f));
        chk("freeze2", 32'(freeze2), 32'(e_f));
        chk("dependency_on_ins2", 32'(dependency_on_ins2), 32'(e_dep));
        @(posedge clk);
        #1;
        chk("issue0_valid", 32'(issue0_valid), 32'(e_d0));
        chk("issue0_instr", issue0_instr, e_d0 ? i0 : 32'd0);
        chk("issue1_valid", 32'(issue1_valid), 32'(e_d1));
        chk("issue1_instr", issue1_instr, e_d1 ? i1 : 32'd0);
        if (e_d0 && i0[6:0] == 7'h03 && i0[11:7] != 5'd0) ready_at[i0[11:7]] = cyc + LOAD_LAT + 1;
        if (e_d1 && i1[6:0] == 7'h03 && i1[11:7] != 5'd0) ready_at[i1[11:7]] = cyc + LOAD_LAT + 1;
        if (e_d0 && is_ctrl(i0)) hold_until = cyc + BRANCH_LAT + 1;
        exp_issued += int'(e_d0) + int'(e_d1);
        if (e_f) exp_stall++;
        cyc++;
`ifdef SCHED_PERF_EN
        chk("perf_issued", perf_issued, 32'(exp_issued));
        chk("perf_stall", perf_stall, 32'(exp_stall));
`endif
    endtask

    function automatic logic [31:0] rand_ins();
        logic [6:0] opc;
        if ($urandom_range(0, 15) == 0) return 32'd0;
        case ($urandom_range(0, 8))
            0: opc = 7'h37;
            1: opc = 7'h17;
            2: opc = 7'h6f;
            3: opc = 7'h67;
            4: opc = 7'h63;
            5: opc = 7'h03;
            6: opc = 7'h23;
            7: opc = 7'h13;
            default: opc = 7'h33;
        endcase
        return {7'($urandom), 5'($urandom_range(0, 4)), 5'($urandom_range(0, 4)),
                3'($urandom), 5'($urandom_range(0, 4)), opc};
    endfunction

    localparam logic [31:0] ADDI_X1 = 32'h00100093;
    localparam logic [31:0] ADDI_X5 = 32'h00500293;
    localparam logic [31:0] ADDI_X2 = 32'h00108113;
    localparam logic [31:0] LW_X3   = 32'h00002183;
    localparam logic [31:0] ADD_X4  = 32'h00118233;
    localparam logic [31:0] BEQ     = 32'h00000463;

    initial begin
        bit nf, er;
        rst = 1'b1;
        nothing_filled = 1'b1;
        instruction0 = 32'd0;
        instruction1 = 32'd0;
        exec_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst issue0_valid", 32'(issue0_valid), 32'd0);
        chk("rst issue1_valid", 32'(issue1_valid), 32'd0);
        chk("rst issue0_instr", issue0_instr, 32'd0);
        chk("rst freeze1", 32'(freeze1), 32'd0);
        rst = 1'b0;

        step(0, ADDI_X1, ADDI_X5, 1);            // dual issue
        step(0, ADDI_X1, ADDI_X2, 1);            // RAW on x1 -> ins0 only
        step(0, LW_X3, ADD_X4, 1);               // load issues alone
        repeat (3) step(0, ADD_X4, 32'd0, 1);    // two stalls, then issue
        step(0, BEQ, ADDI_X5, 1);                // branch alone
        repeat (3) step(0, ADDI_X5, 32'd0, 1);   // two held cycles, then issue
        step(1, ADDI_X1, ADDI_X5, 1);            // empty window
        step(0, ADDI_X1, 32'd0, 0);              // execute not ready

        // Reset asserted mid redirect with a load still pending on x3.
        step(0, LW_X3, 32'd0, 1);
        step(0, BEQ, 32'd0, 1);
        nothing_filled = 1'b0;
        instruction0 = ADD_X4;
        instruction1 = 32'd0;
        exec_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("async issue0_valid", 32'(issue0_valid), 32'd0);
        chk("async issue0_instr", issue0_instr, 32'd0);
        chk("async freeze1", 32'(freeze1), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cyc++;
`ifdef SCHED_PERF_EN
        chk("rst perf_issued", perf_issued, 32'd0);
        chk("rst perf_stall", perf_stall, 32'd0);
`endif
        step(0, ADD_X4, 32'd0, 1);

        for (int k = 0; k < 600; k++) begin
            nf = ($urandom_range(0, 9) == 0);
            er = nf ? 1'b1 : ($urandom_range(0, 7) != 0);
            step(nf, rand_ins(), rand_ins(), er);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
